fft_input_buffer: RTL and testbench

- Ping-pong input stage of the 8-point FFT.
- Accepts complex samples one per cycle over a valid/ready handshake and collects them into frames of 8.
- Presents each completed frame in parallel, in bit-reversed order, to the first butterfly stage.
- Two frame banks, so frame n+1 loads while frame n is held for the butterfly network.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_frame_bank.sv | 51 +++++
 rtl/fft_input_buffer.sv | 88 ++++++++
 tb/tb_fft_input_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point FFT datapath.
package fft_pkg;

   localparam int unsigned FFT_POINTS = 8;
   localparam int unsigned FFT_LOG2   = 3;

   function automatic int unsigned sample_width(input int unsigned n);
      return 32'd1 << n;
   endfunction

   function automatic logic [FFT_LOG2-1:0] bitrev3(input logic [FFT_LOG2-1:0] idx);
      return {idx[0], idx[1], idx[2]};
   endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: 8 complex entries plus a full flag.
// Read ports present the entries in bit-reversed lane order.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [FFT_LOG2-1:0]   widx_i,
   input  logic [W-1:0]          wr_re_i,
   input  logic [W-1:0]          wr_im_i,
   input  logic                  set_full_i,
   input  logic                  clr_full_i,
   output logic                  full_o,
   output logic [FFT_POINTS*W-1:0] rd_re_o,
   output logic [FFT_POINTS*W-1:0] rd_im_o
);

   logic [W-1:0] mem_re_q [FFT_POINTS];
   logic [W-1:0] mem_im_q [FFT_POINTS];
   logic         full_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < FFT_POINTS; i++) begin
            mem_re_q[i] <= '0;
            mem_im_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_re_q[widx_i] <= wr_re_i;
         mem_im_q[widx_i] <= wr_im_i;
      end
   end

   // set and clear are mutually exclusive: set needs !full, clear needs full
   always_ff @(posedge clk) begin
      if (rst)             full_q <= 1'b0;
      else if (set_full_i) full_q <= 1'b1;
      else if (clr_full_i) full_q <= 1'b0;
   end

   assign full_o = full_q;

   for (genvar k = 0; k < FFT_POINTS; k++) begin : g_lane
      assign rd_re_o[k*W +: W] = mem_re_q[bitrev3(FFT_LOG2'(k))];
      assign rd_im_o[k*W +: W] = mem_im_q[bitrev3(FFT_LOG2'(k))];
   end

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong input stage of the 8-point FFT: collects frames of 8 samples
// and presents each completed frame in bit-reversed order.
module fft_input_buffer
   import fft_pkg::*;
#(
   parameter  int unsigned N = 4,
   localparam int unsigned W = sample_width(N)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W-1:0]            in_r,
   input  logic [W-1:0]            in_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [FFT_POINTS*W-1:0] out_r,
   output logic [FFT_POINTS*W-1:0] out_i
);

   logic                wr_sel_q, wr_sel_d;
   logic                rd_sel_q, rd_sel_d;
   logic [FFT_LOG2-1:0] wr_cnt_q, wr_cnt_d;

   logic [1:0]              bank_we, bank_set, bank_clr, bank_full;
   logic [FFT_POINTS*W-1:0] bank_re [2];
   logic [FFT_POINTS*W-1:0] bank_im [2];

   logic accept, consume;

   assign in_ready  = !bank_full[wr_sel_q];
   assign out_valid = bank_full[rd_sel_q];
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   always_comb begin
      wr_sel_d = wr_sel_q;
      wr_cnt_d = wr_cnt_q;
      rd_sel_d = rd_sel_q;
      bank_we  = '0;
      bank_set = '0;
      bank_clr = '0;
      if (accept) begin
         bank_we[wr_sel_q] = 1'b1;
         wr_cnt_d          = wr_cnt_q + 3'd1;
         if (wr_cnt_q == 3'(FFT_POINTS - 1)) begin
            bank_set[wr_sel_q] = 1'b1;
            wr_sel_d           = ~wr_sel_q;
         end
      end
      if (consume) begin
         bank_clr[rd_sel_q] = 1'b1;
         rd_sel_d           = ~rd_sel_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         wr_cnt_q <= '0;
      end else begin
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_frame_bank #(.W(W)) u_bank (
         .clk        (clk),
         .rst        (rst),
         .we_i       (bank_we[b]),
         .widx_i     (wr_cnt_q),
         .wr_re_i    (in_r),
         .wr_im_i    (in_i),
         .set_full_i (bank_set[b]),
         .clr_full_i (bank_clr[b]),
         .full_o     (bank_full[b]),
         .rd_re_o    (bank_re[b]),
         .rd_im_o    (bank_im[b])
      );
   end

   assign out_r = bank_re[rd_sel_q];
   assign out_i = bank_im[rd_sel_q];

endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer: driver pushes expected frames,
// a negedge monitor pops and compares on every consumed frame.
module tb_fft_input_buffer;

   localparam int W  = 16;
   localparam int FW = 8 * W;

   typedef struct packed {
      logic [FW-1:0] r;
      logic [FW-1:0] i;
   } frame_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_r = '0;
   logic [W-1:0]  in_i = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [FW-1:0] out_r;
   logic [FW-1:0] out_i;

   int total = 0;
   int bad   = 0;
   int frames_seen = 0;
   int stall_cnt   = 0;

   frame_t       exp_q[$];
   logic [W-1:0] cur_r [8];
   logic [W-1:0] cur_i [8];
   int           widx = 0;
   int           lane_src [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   fft_input_buffer #(.N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_r      (in_r),
      .in_i      (in_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_i     (out_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic model_accept(input logic [W-1:0] r, input logic [W-1:0] im);
      frame_t f;
      cur_r[widx] = r;
      cur_i[widx] = im;
      widx++;
      if (widx == 8) begin
         for (int k = 0; k < 8; k++) begin
            f.r[k*W +: W] = cur_r[lane_src[k]];
            f.i[k*W +: W] = cur_i[lane_src[k]];
         end
         exp_q.push_back(f);
         widx = 0;
      end
   endtask

   // Holds the sample until accepted; returns #1 after the accepting edge.
   task automatic send(input logic [W-1:0] r, input logic [W-1:0] im);
      int   waits = 0;
      logic rdy;
      in_valid = 1'b1;
      in_r     = r;
      in_i     = im;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (!rdy) waits++;
      end while (!rdy && waits < 200);
      if (!rdy) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready=0 want 1 within 200 cycles");
      end else begin
         model_accept(r, im);
         if (waits > 0) stall_cnt++;
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      widx = 0;
   endtask

   task automatic pulse_ready();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   // monitor
   always @(negedge clk) begin
      frame_t f;
      if (!rst && out_valid && out_ready) begin
         frames_seen++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got out_r=%h want no frame", out_r);
         end else begin
            f = exp_q.pop_front();
            check("frame_r", out_r, f.r);
            check("frame_i", out_i, f.i);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FW-1:0] er, ei, snap_r, snap_i;
      int            fs0, budget;

      // reset state
      do_reset(2);
      check("rst_in_ready", FW'(in_ready), FW'(1));
      check("rst_out_valid", FW'(out_valid), FW'(0));
      check("rst_out_r", out_r, '0);
      check("rst_out_i", out_i, '0);

      // reset mid-frame discards partial frame
      for (int k = 0; k < 4; k++) send(W'(100 + k), W'(300 + k));
      idle();
      do_reset(3);
      for (int k = 0; k < 8; k++) send(W'(200 + k), W'(400 + k));
      idle();
      check("midrst_valid", FW'(out_valid), FW'(1));
      pulse_ready();

      // single frame, held with out_ready=0
      for (int k = 0; k < 8; k++) begin
         send(W'(k), W'(-k));
         if (k == 6) check("sf_not_yet_valid", FW'(out_valid), FW'(0));
      end
      idle();
      check("sf_valid_rise", FW'(out_valid), FW'(1));
      er = {16'd7, 16'd3, 16'd5, 16'd1, 16'd6, 16'd2, 16'd4, 16'd0};
      ei = {-16'sd7, -16'sd3, -16'sd5, -16'sd1, -16'sd6, -16'sd2, -16'sd4, 16'd0};
      check("sf_lanes_r", out_r, er);
      check("sf_lanes_i", out_i, ei);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check("sf_hold_r", out_r, er);
         check("sf_hold_i", out_i, ei);
      end
      check("sf_hold_valid", FW'(out_valid), FW'(1));
      pulse_ready();

      // ping-pong backpressure
      for (int k = 0; k < 16; k++) send(W'(16 + k), W'(k));
      check("pp_in_ready_low", FW'(in_ready), FW'(0));
      check("pp_out_valid", FW'(out_valid), FW'(1));
      snap_r = out_r;
      snap_i = out_i;
      in_r = 16'hDEAD;
      in_i = 16'hBEEF;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("pp_drop_ready", FW'(in_ready), FW'(0));
      end
      idle();
      check("pp_drop_hold_r", out_r, snap_r);
      check("pp_drop_hold_i", out_i, snap_i);
      pulse_ready();
      check("pp_valid_after", FW'(out_valid), FW'(1));
      check("pp_ready_after", FW'(in_ready), FW'(1));
      pulse_ready();
      check("pp_drained", FW'(out_valid), FW'(0));

      // simultaneous complete / consume
      for (int k = 0; k < 15; k++) send(W'(500 + k), W'(600 + k));
      out_ready = 1'b1;
      send(W'(515), W'(615));
      out_ready = 1'b0;
      idle();
      check("sim_valid", FW'(out_valid), FW'(1));
      check("sim_in_ready", FW'(in_ready), FW'(1));
      for (int k = 0; k < 8; k++) send(W'(700 + k), W'(800 + k));
      idle();
      check("sim_both_full", FW'(in_ready), FW'(0));
      pulse_ready();
      pulse_ready();

      // streaming, no bubbles
      stall_cnt  = 0;
      out_ready  = 1'b1;
      fs0        = frames_seen;
      for (int c = 0; c < 64; c++) send(W'(c), W'(c) ^ 16'h5A5A);
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("stream_stalls", FW'(stall_cnt), FW'(0));
      check("stream_frames", FW'(frames_seen - fs0), FW'(8));
      out_ready = 1'b0;

      // extremes pass bit-exact
      for (int k = 0; k < 8; k++)
         send((k % 2 == 0) ? 16'h7FFF : 16'h8000, (k % 2 == 0) ? 16'h8000 : 16'h7FFF);
      idle();
      check("ext_lane0_r", FW'(out_r[15:0]), FW'(16'h7FFF));
      check("ext_lane4_r", FW'(out_r[79:64]), FW'(16'h8000));
      pulse_ready();

      // drain
      out_ready = 1'b1;
      budget = 0;
      while (exp_q.size() != 0 && budget < 50) begin
         @(posedge clk);
         budget++;
      end
      #1;
      out_ready = 1'b0;
      check("final_queue_empty", FW'(exp_q.size()), FW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
